// File: rtl/int_pkg.sv
// Shared types and defaults for the interrupt arbiter: FSM encoding and vector layout.
// Pure declarations; no logic, no latency.
package int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CLR  = 2'd2
  } state_t;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0800;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

  // Handler address for a source id; wraps at 32 bits.
  function automatic logic [31:0] vec_of(input logic [31:0] base,
                                         input logic [31:0] stride,
                                         input logic [31:0] id);
    return base + (stride * id);
  endfunction

endpackage

// File: rtl/int_priority_enc.sv
// Lowest-index-first finder over an N-bit vector, returning {vld, id}.
// Purely combinational; no backpressure.
module int_priority_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_vec,
  output logic         vld,
  output logic [W-1:0] id
);

  always_comb begin
    vld = |req_vec;
    id  = '0;
    // Walk downwards so the lowest set index is the last write.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_vec[i]) id = W'(i);
    end
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// Masks and prioritises sampler flags, raises one registered irq (1 cycle after eligible),
// tracks nested in-service sources and pulses a one-hot clear one cycle after int_ack.
module interrupt_arbiter
  import int_pkg::*;
#(
  parameter int          NUM_SRC    = 4,
  parameter int          ID_W       = 2,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_ind,
  output logic [NUM_SRC-1:0] src_clr,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask,
  input  logic               gie,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [31:0]        irq_vec,
  input  logic               int_ack,
  input  logic               eret,
  output logic [NUM_SRC-1:0] in_service
);

  state_t             state_q, state_d;
  logic               irq_q, irq_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [31:0]        irq_vec_q, irq_vec_d;
  logic [NUM_SRC-1:0] src_clr_q, src_clr_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] in_service_q, in_service_d;

  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] prio_allow;
  logic [NUM_SRC-1:0] eligible;
  logic               elig_vld;
  logic [ID_W-1:0]    elig_id;
  logic               isv_vld;
  logic [ID_W-1:0]    isv_id;
  logic [NUM_SRC-1:0] eret_clr;
  logic [NUM_SRC-1:0] ack_set;
  logic               keep_req;

  int_priority_enc #(.N(NUM_SRC), .W(ID_W)) u_isv_enc (
    .req_vec (in_service_q),
    .vld     (isv_vld),
    .id      (isv_id)
  );

  int_priority_enc #(.N(NUM_SRC), .W(ID_W)) u_elig_enc (
    .req_vec (eligible),
    .vld     (elig_vld),
    .id      (elig_id)
  );

  // Only sources of strictly higher priority than the active handler may nest.
  always_comb begin
    prio_allow = '1;
    if (isv_vld) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        prio_allow[i] = (ID_W'(i) < isv_id);
      end
    end
  end

  assign cand     = src_ind & mask_q & ~in_service_q;
  assign eligible = cand & prio_allow;
  assign keep_req = gie & mask_q[irq_id_q] & src_ind[irq_id_q];

  always_comb begin
    state_d   = state_q;
    irq_d     = irq_q;
    irq_id_d  = irq_id_q;
    irq_vec_d = irq_vec_q;
    src_clr_d = '0;
    mask_d    = mask_we ? mask_wdata : mask_q;
    eret_clr  = '0;
    ack_set   = '0;

    if (eret && isv_vld) eret_clr = NUM_SRC'(1) << isv_id;

    case (state_q)
      ST_IDLE: begin
        irq_d = 1'b0;
        if (gie && elig_vld) begin
          irq_d     = 1'b1;
          irq_id_d  = elig_id;
          irq_vec_d = vec_of(VEC_BASE, VEC_STRIDE, 32'(elig_id));
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          ack_set   = NUM_SRC'(1) << irq_id_q;
          src_clr_d = NUM_SRC'(1) << irq_id_q;
          irq_d     = 1'b0;
          state_d   = ST_CLR;
        end else if (!keep_req) begin
          irq_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        irq_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // An eret in the same cycle as an ack retires the old handler before the new one enters.
    in_service_d = (in_service_q & ~eret_clr) | ack_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      irq_q        <= 1'b0;
      irq_id_q     <= '0;
      irq_vec_q    <= VEC_BASE;
      src_clr_q    <= '0;
      mask_q       <= '1;
      in_service_q <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_d;
      irq_id_q     <= irq_id_d;
      irq_vec_q    <= irq_vec_d;
      src_clr_q    <= src_clr_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
    end
  end

  assign irq        = irq_q;
  assign irq_id     = irq_id_q;
  assign irq_vec    = irq_vec_q;
  assign src_clr    = src_clr_q;
  assign mask       = mask_q;
  assign in_service = in_service_q;

endmodule
